// File: rtl/cache_addr_gen.sv
// Address-trace generator feeding the direct-mapped cache: seq / stride / loop / random streams.
// Optional macro ADDR_GEN_RANDOM_EN adds the LFSR-driven random mode; without it mode 11 acts as seq.
module cache_addr_gen #(
    parameter int unsigned LOOP_LEN  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] stride_i,
    input  logic [15:0] count_i,
    input  logic        addr_ready_i,
    output logic [31:0] address_o,
    output logic        addr_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] issued_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] LOOP_MASK = 32'(LOOP_LEN - 1);

    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] base_q, base_d;
    logic [15:0] stride_q, stride_d;
    logic [15:0] count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] issued_q, issued_d;
    logic [31:0] k_q, k_d;

    logic [31:0] base_aligned_s;
    logic [31:0] first_addr_s;
    logic [31:0] next_addr_s;
    logic [31:0] k_next_s;
    logic        accept_s;

`ifdef ADDR_GEN_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] lfsr_next_s;

    // Fibonacci LFSR, taps 16/14/13/11, shifting toward the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign lfsr_next_s = lfsr_step(lfsr_q);
`endif

    assign base_aligned_s = {base_addr_i[31:2], 2'b00};
    assign accept_s       = (state_q == ST_RUN) && addr_ready_i;
    assign k_next_s       = (k_q + 32'd1) & LOOP_MASK;

    // First address of a trace, derived from the config being latched.
    always_comb begin
        first_addr_s = base_aligned_s;
        case (mode_i)
            2'b00:   first_addr_s = base_aligned_s;
            2'b01:   first_addr_s = base_aligned_s;
            2'b10:   first_addr_s = base_aligned_s;
`ifdef ADDR_GEN_RANDOM_EN
            2'b11:   first_addr_s = base_aligned_s + {14'd0, LFSR_SEED, 2'b00};
`else
            2'b11:   first_addr_s = base_aligned_s;
`endif
            default: first_addr_s = base_aligned_s;
        endcase
    end

    // Address presented after the current one is accepted.
    always_comb begin
        next_addr_s = addr_q + 32'd4;
        case (mode_q)
            2'b00:   next_addr_s = addr_q + 32'd4;
            2'b01:   next_addr_s = addr_q + {14'd0, stride_q, 2'b00};
            2'b10:   next_addr_s = base_q + (k_next_s << 2);
`ifdef ADDR_GEN_RANDOM_EN
            2'b11:   next_addr_s = base_q + {14'd0, lfsr_next_s, 2'b00};
`else
            2'b11:   next_addr_s = addr_q + 32'd4;
`endif
            default: next_addr_s = addr_q + 32'd4;
        endcase
    end

    // Trace FSM next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        base_d   = base_q;
        stride_d = stride_q;
        count_d  = count_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        k_d      = k_q;
`ifdef ADDR_GEN_RANDOM_EN
        lfsr_d   = lfsr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d   = mode_i;
                    base_d   = base_aligned_s;
                    stride_d = stride_i;
                    count_d  = count_i;
                    issued_d = 16'd0;
                    k_d      = 32'd0;
                    addr_d   = first_addr_s;
`ifdef ADDR_GEN_RANDOM_EN
                    lfsr_d   = LFSR_SEED;
`endif
                    if (count_i == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    issued_d = issued_q + 16'd1;
`ifdef ADDR_GEN_RANDOM_EN
                    lfsr_d   = lfsr_next_s;
`endif
                    if ((issued_q + 16'd1) == count_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        addr_d  = next_addr_s;
                        k_d     = k_next_s;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= 2'b00;
            base_q   <= 32'd0;
            stride_q <= 16'd0;
            count_q  <= 16'd0;
            addr_q   <= 32'd0;
            issued_q <= 16'd0;
            k_q      <= 32'd0;
`ifdef ADDR_GEN_RANDOM_EN
            lfsr_q   <= LFSR_SEED;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            k_q      <= k_d;
`ifdef ADDR_GEN_RANDOM_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    assign address_o    = addr_q;
    assign addr_valid_o = (state_q == ST_RUN);
    assign busy_o       = (state_q == ST_RUN);
    assign done_o       = (state_q == ST_DONE);
    assign issued_o     = issued_q;

endmodule
